// File: rtl/rr_sel_pkg.sv
// Shared types and helpers for the 8-channel round-robin selector.
package rr_sel_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    typedef logic [SEL_W-1:0] ch_idx_t;

    // One-hot decode of a channel index.
    function automatic logic [N_CH-1:0] idx_to_onehot(input ch_idx_t idx);
        logic [N_CH-1:0] one;
        one = {{(N_CH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_sel_8_pick.sv
// Combinational round-robin picker: first set request at or after base, wrapping.
module rr_pick
    import rr_sel_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         base,
    output ch_idx_t         idx,
    output logic            any
);

    logic [2*N_CH-1:0] dbl_s;
    logic [N_CH-1:0]   rot_s;
    ch_idx_t           off_s;

    // Doubling the vector lets a variable part-select perform the rotate-right by base.
    assign dbl_s = {req, req};
    assign rot_s = dbl_s[base +: N_CH];

    // Fixed LSB-first priority on the rotated vector; the lowest set bit wins.
    always_comb begin
        off_s = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = ch_idx_t'(k);
            end else begin
                off_s = off_s;
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps modulo 8 naturally.
    assign idx = off_s + base;
    assign any = |req;

endmodule

// File: rtl/rr_sel_8.sv
// Round-robin arbiter driving the select of an 8:1 mux; grant held until ack or timeout.
module rr_sel_8
    import rr_sel_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            ack,
    output logic [SEL_W-1:0] sel,
    output logic            gnt_valid,
    output logic [N_CH-1:0] gnt_onehot,
    output logic            timeout
);

    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam int              TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    rr_state_t       state_q, state_d;
    ch_idx_t         ptr_q, ptr_d;
    ch_idx_t         sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [N_CH-1:0] onehot_q, onehot_d;
    logic            timeout_q, timeout_d;

    ch_idx_t         pick_idx_s;
    logic            pick_any_s;

    rr_pick u_pick (
        .req  (req),
        .base (ptr_q),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Next-state logic: arbitrate in IDLE, hold and count in GRANT, release on ack or timeout.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        gnt_valid_d = gnt_valid_q;
        onehot_d    = onehot_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d     = GRANT;
                    sel_d       = pick_idx_s;
                    onehot_d    = idx_to_onehot(pick_idx_s);
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    gnt_valid_d = 1'b0;
                    onehot_d    = '0;
                end
            end
            GRANT: begin
                if (ack || (TO_EN && (cnt_q == TO_LAST))) begin
                    // Ack wins over a coinciding timeout, so the pulse fires only without ack.
                    state_d     = IDLE;
                    ptr_d       = sel_q + 3'd1;
                    cnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    onehot_d    = '0;
                    timeout_d   = ~ack;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
                onehot_d    = '0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            sel_q       <= 3'd0;
            cnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            onehot_q    <= 8'h00;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            gnt_valid_q <= gnt_valid_d;
            onehot_q    <= onehot_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sel        = sel_q;
    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = onehot_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_sel_8.sv
// Directed and randomized self-checking bench for rr_sel_8.
module tb_rr_sel_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] sel;
    logic       gnt_valid;
    logic [7:0] gnt_onehot;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mux_data [8];
    int         wait_c   [8];

    rr_sel_8 #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .sel        (sel),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] drv_req;
        logic [7:0] y_mux;
        logic [7:0] y_ref;
        logic       prev_gv;
        int         max_wait;

        rst = 1'b1;
        req = 8'hFF;
        ack = 1'b0;

        // 1. reset held with all requests set
        step();
        chk("rst1_sel", {5'd0, sel}, 8'd0);
        chk("rst1_gv", {7'd0, gnt_valid}, 8'd0);
        chk("rst1_oh", gnt_onehot, 8'h00);
        step();
        chk("rst2_sel", {5'd0, sel}, 8'd0);
        chk("rst2_gv", {7'd0, gnt_valid}, 8'd0);
        chk("rst2_oh", gnt_onehot, 8'h00);
        chk("rst2_to", {7'd0, timeout}, 8'd0);

        // 2. two requesters alternate: 2, 5, 2
        req = 8'b0010_0100;
        rst = 1'b0;
        step();
        chk("t2_gv_a", {7'd0, gnt_valid}, 8'd1);
        chk("t2_sel_a", {5'd0, sel}, 8'd2);
        chk("t2_oh_a", gnt_onehot, 8'h04);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_bubble_a", {7'd0, gnt_valid}, 8'd0);
        chk("t2_oh_bub", gnt_onehot, 8'h00);
        step();
        chk("t2_sel_b", {5'd0, sel}, 8'd5);
        chk("t2_oh_b", gnt_onehot, 8'h20);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("t2_sel_c", {5'd0, sel}, 8'd2);
        chk("t2_oh_c", gnt_onehot, 8'h04);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 3. all requesting, immediate acks: 0..7 then wrap to 0
        req = 8'hFF;
        do_reset();
        step();
        for (int i = 0; i < 9; i++) begin
            chk("t3_gv", {7'd0, gnt_valid}, 8'd1);
            chk("t3_sel", {5'd0, sel}, 8'(i % 8));
            chk("t3_oh", gnt_onehot, 8'h01 << (i % 8));
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("t3_bubble", {7'd0, gnt_valid}, 8'd0);
            step();
        end

        // 4. timeout with a lone requester on channel 7
        req = 8'h80;
        do_reset();
        step();
        for (int k = 0; k < 16; k++) begin
            chk("t4_hold_gv", {7'd0, gnt_valid}, 8'd1);
            chk("t4_hold_sel", {5'd0, sel}, 8'd7);
            chk("t4_hold_to", {7'd0, timeout}, 8'd0);
            step();
        end
        chk("t4_rel_gv", {7'd0, gnt_valid}, 8'd0);
        chk("t4_rel_to", {7'd0, timeout}, 8'd1);
        step();
        chk("t4_next_gv", {7'd0, gnt_valid}, 8'd1);
        chk("t4_next_sel", {5'd0, sel}, 8'd7);
        chk("t4_next_to", {7'd0, timeout}, 8'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 5. request dropped mid-grant; ack coincides with the last timeout cycle
        req = 8'h08;
        do_reset();
        step();
        chk("t5_sel", {5'd0, sel}, 8'd3);
        req = 8'h00;
        for (int k = 1; k < 16; k++) begin
            step();
            chk("t5_hold_gv", {7'd0, gnt_valid}, 8'd1);
            chk("t5_hold_oh", gnt_onehot, 8'h08);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t5_rel_gv", {7'd0, gnt_valid}, 8'd0);
        chk("t5_no_to", {7'd0, timeout}, 8'd0);
        step();
        chk("t5_no_to2", {7'd0, timeout}, 8'd0);

        // 6. reset in the middle of a grant on channel 6
        req = 8'h40;
        do_reset();
        step();
        chk("t6_sel_pre", {5'd0, sel}, 8'd6);
        rst = 1'b1;
        step();
        chk("t6_rst_gv", {7'd0, gnt_valid}, 8'd0);
        chk("t6_rst_sel", {5'd0, sel}, 8'd0);
        chk("t6_rst_oh", gnt_onehot, 8'h00);
        rst = 1'b0;
        step();
        chk("t6_post_gv", {7'd0, gnt_valid}, 8'd1);
        chk("t6_post_sel", {5'd0, sel}, 8'd6);

        // Random traffic: one-hot consistency, mux output, and starvation bound
        for (int i = 0; i < 8; i++) begin
            mux_data[i] = 8'($urandom);
            wait_c[i]   = 0;
        end
        req = 8'h00;
        do_reset();
        prev_gv = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drv_req = 8'($urandom);
            req = drv_req;
            ack = ($urandom_range(0, 3) == 0);
            step();
            chk("rnd_oh", gnt_onehot, (8'h01 << sel) & {8{gnt_valid}});
            if (gnt_valid) begin
                y_mux = mux_data[sel];
                y_ref = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (gnt_onehot[i]) y_ref = y_ref | mux_data[i];
                end
                chk("rnd_mux_y", y_mux, y_ref);
            end
            if (gnt_valid && !prev_gv) begin
                max_wait = 0;
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(sel)) wait_c[i] = 0;
                    else if (drv_req[i]) wait_c[i] = wait_c[i] + 1;
                    else wait_c[i] = 0;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
                chk("rnd_starve", (max_wait > 7) ? 8'd1 : 8'd0, 8'd0);
            end
            prev_gv = gnt_valid;
        end
        ack = 1'b0;
        req = 8'h00;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
